mem_arbiter_rr: RTL
===================

// Module: mem_arbiter_rr
// PURPOSE
//  N-master arbiter between the cache/uncache front ends (icache, dcache, uncache, ...)
//  and the single AXI4 bridge. Independent read and write channels, each with a
//  registered grant held for the whole transaction. Round-robin or fixed priority.
//  Read data and completions are routed back by transaction ID.
// PARAMETERS
//  NUM_M     3    number of masters (index 0 = highest fixed priority); 2..8
//  ADDR_W    32   address width
//  DATA_W    64   data width; MASK_W = DATA_W/8
//  ID_W      2    ID width; must satisfy 2**ID_W >= NUM_M
//  RR_EN     1    1 = round-robin, 0 = fixed priority (lowest index wins)
// PORTS
//  clk          in   1            clock, rising edge
//  rst          in   1            reset, asynchronous, active-low
//  m_re_i       in   NUM_M        per-master read request; held until m_rvalid_o
//  m_we_i       in   NUM_M        per-master write request; held until m_wdone_o
//  m_addr_i     in   NUM_M*ADDR_W packed addresses, master k at [k*ADDR_W +: ADDR_W]
//  m_wdata_i    in   NUM_M*DATA_W packed write data
//  m_mask_i     in   NUM_M*MASK_W packed byte strobes
//  m_rdata_o    out  DATA_W       shared read-return data bus
//  m_rvalid_o   out  NUM_M        one-hot read-complete pulse
//  m_wdone_o    out  NUM_M        one-hot write-complete pulse
//  ar_e_o       out  1            read address request to bridge
//  ar_id_o      out  ID_W         read ID = granted master index
//  ar_addr_o    out  ADDR_W       read address
//  r_data_i     in   DATA_W       read data from bridge
//  r_id_i       in   ID_W         read return ID
//  r_over_i     in   1            read transaction finished (1-cycle pulse)
//  aw_e_o       out  1            write request to bridge
//  aw_id_o      out  ID_W         write ID = granted master index
//  aw_addr_o    out  ADDR_W       write address
//  w_data_o     out  DATA_W       write data
//  w_mask_o     out  MASK_W       write byte strobes
//  b_over_i     in   1            write response received (1-cycle pulse)
//  err_o        out  1            sticky: r_over_i with r_id_i != current read grant
// BEHAVIOUR
//  - Reset (rst=0, async): both FSMs IDLE, grants 0, RR pointers 0, err_o 0; all outputs 0.
//  - Read FSM: IDLE -> BUSY when any m_re_i set; grant registered at that edge.
//    BUSY: ar_e_o=1, ar_id_o=grant, ar_addr_o=m_addr_i[grant] (live mux of held addr).
//    BUSY -> IDLE on r_over_i && r_id_i==grant; ar_e_o low the next cycle.
//  - Latency: request at cycle 0 -> ar_e_o at cycle 1; min one IDLE cycle between grants.
//  - Return routing (combinational): m_rdata_o = r_data_i when r_over_i else 0;
//    m_rvalid_o[r_id_i] = r_over_i && r_id_i==grant && state BUSY; else 0.
//  - r_over_i with mismatching ID or in IDLE: ignored, sets err_o; FSM unchanged.
//  - Write FSM: identical structure, aw_e_o/aw_id_o/aw_addr_o/w_data_o/w_mask_o from
//    granted master; BUSY -> IDLE on b_over_i; m_wdone_o[grant] = b_over_i in BUSY.
//  - Arbitration (RR_EN=1): search starts at pointer; on grant, pointer <= grant+1,
//    wrapping NUM_M-1 -> 0. RR_EN=0: lowest set index wins, pointer unused.
//  - Read and write channels fully independent; same master may own both at once.
//  - Master dropping its request while BUSY: transaction still completes, pulse still
//    issued; masters must not drop requests (bench asserts this).
//  - Pulse arriving on the same cycle as a new request: completion handled first;
//    new request granted from IDLE on the following edge.
//  - ID_W wider than needed: upper ID bits of outputs 0; r_id_i >= NUM_M -> err_o.
// STRUCTURE
//  - defines.v: ID_W default, FSM state encodings (ARB_IDLE=0, ARB_BUSY=1).
//  - Sub-module rr_pick (req vector, pointer, RR_EN -> one-hot grant + index), pure
//    combinational, instantiated once for read, once for write.
//  - Top holds two 1-bit FSMs, two grant/pointer registers, output muxes, err flag.
// TESTING
//  1 Reset mid-BUSY: rst low while ar_e_o=1 -> ar_e_o, grants, err_o 0 immediately.
//  2 Single read: m_re_i=3'b010, addr 0x8000_0040 -> cycle1 ar_e_o=1, ar_id_o=1;
//    r_over_i, r_id_i=1, data 0xDEAD_BEEF_0000_0001 -> m_rvalid_o=3'b010, same data.
//  3 Round-robin: m_re_i=3'b111 held -> grant order 0,1,2,0; RR_EN=0 -> 0,0,0.
//  4 Concurrent channels: m_re_i=3'b001, m_we_i=3'b100 mask 8'h0F -> ar_id_o=0 and
//    aw_id_o=2 both asserted cycle1; b_over_i -> m_wdone_o=3'b100 only.
//  5 Bad ID: grant 0, r_over_i with r_id_i=2 -> no m_rvalid_o, err_o=1, still BUSY.
//  6 NUM_M=5, ID_W=3: m_re_i=5'b10000 -> ar_id_o=3'd4; pointer wraps to 0.

Source files
------------

// File: rtl/mem_arbiter_rr_pkg.sv
// Shared types and helpers for the round-robin memory arbiter between the
// cache/uncache front ends and the single AXI4 bridge.
package mem_arbiter_rr_pkg;

  localparam int ID_W_DEF = 2;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  // Round-robin pointer advance: the master after the winner, wrapping to 0.
  function automatic int next_idx(input int idx, input int num_m);
    return (idx + 1 >= num_m) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational requester picker: round-robin search starting at ptr_i, or
// plain lowest-index-wins when RR_EN is 0.
module mem_arbiter_rr_pick #(
  parameter int NUM_M = 3,
  parameter int ID_W  = 2,
  parameter bit RR_EN = 1'b1
) (
  input  logic [NUM_M-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [ID_W-1:0]  gnt_idx_o,
  output logic             valid_o
);

  logic [ID_W-1:0]  start;
  logic [NUM_M-1:0] hi_req;
  logic [NUM_M-1:0] cand;

  // Requests at or above the pointer win; if none, wrap to the lowest request.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the block leaves a value held and no latch is inferred.
    start     = RR_EN ? ptr_i : '0;
    hi_req    = '0;
    gnt_idx_o = '0;
    for (int k = 0; k < NUM_M; k++) begin
      hi_req[k] = req_i[k] && (k >= int'(start));
    end
    cand = (|hi_req) ? hi_req : req_i;
    for (int k = NUM_M - 1; k >= 0; k--) begin
      if (cand[k]) gnt_idx_o = ID_W'(k);
    end
    valid_o = |req_i;
  end

endmodule

// File: rtl/mem_arbiter_rr.sv
// N-master arbiter in front of one AXI4 bridge: independent read and write
// channels, each granting one master for a whole transaction.
module mem_arbiter_rr
  import mem_arbiter_rr_pkg::*;
#(
  parameter int NUM_M  = 3,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W   = ID_W_DEF,
  parameter bit RR_EN  = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_M-1:0]           m_re_i,
  input  logic [NUM_M-1:0]           m_we_i,
  input  logic [NUM_M*ADDR_W-1:0]    m_addr_i,
  input  logic [NUM_M*DATA_W-1:0]    m_wdata_i,
  input  logic [NUM_M*DATA_W/8-1:0]  m_mask_i,
  output logic [DATA_W-1:0]          m_rdata_o,
  output logic [NUM_M-1:0]           m_rvalid_o,
  output logic [NUM_M-1:0]           m_wdone_o,
  output logic                       ar_e_o,
  output logic [ID_W-1:0]            ar_id_o,
  output logic [ADDR_W-1:0]          ar_addr_o,
  input  logic [DATA_W-1:0]          r_data_i,
  input  logic [ID_W-1:0]            r_id_i,
  input  logic                       r_over_i,
  output logic                       aw_e_o,
  output logic [ID_W-1:0]            aw_id_o,
  output logic [ADDR_W-1:0]          aw_addr_o,
  output logic [DATA_W-1:0]          w_data_o,
  output logic [DATA_W/8-1:0]        w_mask_o,
  input  logic                       b_over_i,
  output logic                       err_o
);

  localparam int MASK_W = DATA_W / 8;

  arb_state_e      rd_state_q, rd_state_d, wr_state_q, wr_state_d;
  logic [ID_W-1:0] rd_gnt_q, rd_gnt_d, rd_ptr_q, rd_ptr_d;
  logic [ID_W-1:0] wr_gnt_q, wr_gnt_d, wr_ptr_q, wr_ptr_d;
  logic            err_q, err_d;
  logic [ID_W-1:0] rd_pick, wr_pick;
  logic            rd_any, wr_any;
  logic            rd_busy, wr_busy, rd_hit, wr_hit;

  mem_arbiter_rr_pick #(.NUM_M(NUM_M), .ID_W(ID_W), .RR_EN(RR_EN)) u_rd_pick (
    .req_i     (m_re_i),
    .ptr_i     (rd_ptr_q),
    .gnt_idx_o (rd_pick),
    .valid_o   (rd_any)
  );

  mem_arbiter_rr_pick #(.NUM_M(NUM_M), .ID_W(ID_W), .RR_EN(RR_EN)) u_wr_pick (
    .req_i     (m_we_i),
    .ptr_i     (wr_ptr_q),
    .gnt_idx_o (wr_pick),
    .valid_o   (wr_any)
  );

  assign rd_busy = (rd_state_q == ARB_BUSY);
  assign wr_busy = (wr_state_q == ARB_BUSY);
  // Only a completion carrying the owner's ID ends the read; anything else is an error.
  assign rd_hit  = rd_busy && r_over_i && (r_id_i == rd_gnt_q);
  assign wr_hit  = wr_busy && b_over_i;

  always_comb begin
    rd_state_d = rd_state_q;
    rd_gnt_d   = rd_gnt_q;
    rd_ptr_d   = rd_ptr_q;
    case (rd_state_q)
      ARB_IDLE: if (rd_any) begin
        rd_state_d = ARB_BUSY;
        rd_gnt_d   = rd_pick;
        if (RR_EN) rd_ptr_d = ID_W'(next_idx(int'(rd_pick), NUM_M));
      end
      ARB_BUSY: if (rd_hit) rd_state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    wr_state_d = wr_state_q;
    wr_gnt_d   = wr_gnt_q;
    wr_ptr_d   = wr_ptr_q;
    case (wr_state_q)
      ARB_IDLE: if (wr_any) begin
        wr_state_d = ARB_BUSY;
        wr_gnt_d   = wr_pick;
        if (RR_EN) wr_ptr_d = ID_W'(next_idx(int'(wr_pick), NUM_M));
      end
      ARB_BUSY: if (wr_hit) wr_state_d = ARB_IDLE;
    endcase
  end

  assign err_d = err_q | (r_over_i & ~rd_hit);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; the reset is asynchronous and needs no clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_state_q <= ARB_IDLE;
      wr_state_q <= ARB_IDLE;
      rd_gnt_q   <= '0;
      rd_ptr_q   <= '0;
      wr_gnt_q   <= '0;
      wr_ptr_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      wr_state_q <= wr_state_d;
      rd_gnt_q   <= rd_gnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_gnt_q   <= wr_gnt_d;
      wr_ptr_q   <= wr_ptr_d;
      err_q      <= err_d;
    end
  end

  // Live muxes of the owner's held request fields; all zero while idle.
  always_comb begin
    ar_addr_o  = '0;
    aw_addr_o  = '0;
    w_data_o   = '0;
    w_mask_o   = '0;
    m_rvalid_o = '0;
    m_wdone_o  = '0;
    for (int k = 0; k < NUM_M; k++) begin
      if (rd_busy && rd_gnt_q == ID_W'(k)) ar_addr_o = m_addr_i[k*ADDR_W +: ADDR_W];
      if (wr_busy && wr_gnt_q == ID_W'(k)) begin
        aw_addr_o = m_addr_i[k*ADDR_W +: ADDR_W];
        w_data_o  = m_wdata_i[k*DATA_W +: DATA_W];
        w_mask_o  = m_mask_i[k*MASK_W +: MASK_W];
      end
      m_rvalid_o[k] = rd_hit && (rd_gnt_q == ID_W'(k));
      m_wdone_o[k]  = wr_hit && (wr_gnt_q == ID_W'(k));
    end
  end

  assign ar_e_o    = rd_busy;
  assign ar_id_o   = rd_busy ? rd_gnt_q : '0;
  assign aw_e_o    = wr_busy;
  assign aw_id_o   = wr_busy ? wr_gnt_q : '0;
  assign m_rdata_o = r_over_i ? r_data_i : '0;
  assign err_o     = err_q;

endmodule
